weight_buf: RTL and testbench
=============================

WEIGHT_BUF -- requirements
Module: weight_buf

Interface
REQ-001 SHALL have parameter DW, default 8: weight width in bits.
REQ-002 SHALL have parameter K, default 3: kernel side; the kernel is K*K.
REQ-003 SHALL have parameter CIN, default 3: input channels.
REQ-004 SHALL have parameter NSET, default 2: weight sets (set 0 is conv, set 1 is connect).
REQ-005 SHALL define derived DEPTH = K*K*CIN*NSET and AW = $clog2(DEPTH).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port load_start, input, 1 bit: one-cycle pulse that opens a load into the shadow bank.
REQ-009 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, DW) and s_last (input, 1): the byte-stream load channel.
REQ-010 SHALL have port swap, input, 1 bit: pulse that promotes the shadow bank to active.
REQ-011 SHALL have port dout, output, DEPTH*DW bits: all active-bank weights, with entry i at bits [i*DW +: DW].
REQ-012 SHALL have port dout_valid, output, 1 bit: the active bank holds a complete load.
REQ-013 SHALL have port loaded, output, 1 bit: the shadow bank is complete and awaiting swap.
REQ-014 SHALL have port err, output, 1 bit: sticky load-framing error.

Function
REQ-015 SHALL implement two banks of DEPTH x DW (ping-pong), with one-bit register act_sel naming the active bank; the other bank is the shadow.
REQ-016 SHALL implement FSM states IDLE, LOAD and FULL.
REQ-017 SHALL, in IDLE with load_start=1, clear waddr to 0, clear err, and go to LOAD next cycle.
REQ-018 SHALL ignore load_start in LOAD and FULL.
REQ-019 SHALL drive s_ready=1 only in LOAD; a beat transfers when s_valid and s_ready are both 1.
REQ-020 SHALL, per transferred beat, write s_data to shadow[waddr] in the same edge, then increment waddr.
REQ-021 SHALL, on a beat at waddr==DEPTH-1 with s_last=1, go to FULL and set loaded=1.
REQ-022 SHALL, on a beat at waddr==DEPTH-1 with s_last=0, set err=1 and go to FULL; the data is kept.
REQ-023 SHALL, on a beat with s_last=1 at waddr<DEPTH-1, set err=1, go to IDLE and leave loaded=0; the shadow contents are then undefined.
REQ-024 SHALL, in FULL with swap=1, toggle act_sel, set dout_valid=1, clear loaded, and go to IDLE, all on the same edge.
REQ-025 SHALL ignore swap in IDLE and LOAD; the active bank and dout are unchanged.
REQ-026 SHALL drive dout combinationally from the active bank; dout reflects the new bank in the cycle after the swap edge (latency 1).
REQ-027 SHALL never write the active bank; a load concurrent with inference SHALL NOT disturb dout.
REQ-028 SHALL, when load_start and swap are both 1 in FULL, perform the swap; a load_start in the following IDLE cycle starts a new load.
REQ-029 SHALL size waddr to AW bits and never wrap it; waddr is held at DEPTH-1 by the exit rules.
REQ-030 SHALL hold err until the next accepted load_start or reset.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously force: state=IDLE, waddr=0, act_sel=0, dout_valid=0, loaded=0, err=0, s_ready=0.
REQ-032 SHALL NOT reset the bank storage; dout is undefined while dout_valid=0.
REQ-033 SHALL, on reset during LOAD, abandon the partial load; a new load_start is required.

Structure
REQ-034 SHALL place the FSM state enum and a depth/address-width helper function in package weight_buf_pkg.
REQ-035 SHALL instantiate sub-module weight_bank twice; each instance has a DEPTH x DW array, a synchronous write port (wen, waddr, din) and a flat combinational read output.
REQ-036 SHALL implement bank select, the FSM and the counters in weight_buf only.

Verification
REQ-037 SHALL cover: defaults, load_start, then 54 beats of values 1..54 with s_last on beat 54, then swap -> dout[7:0]=1, dout[431:424]=54, dout_valid=1, err=0.
REQ-038 SHALL cover: s_last on beat 10 of 54 -> err=1, FSM in IDLE, loaded=0, dout and dout_valid unchanged.
REQ-039 SHALL cover: a second load of values 0xA0+i with s_valid toggled randomly while the first bank is active -> dout stable until swap, then dout[7:0]=0xA0.
REQ-040 SHALL cover: swap pulsed in IDLE and in LOAD -> act_sel, dout and dout_valid unchanged.
REQ-041 SHALL cover: rst_n asserted at beat 20 mid-load -> all outputs at reset values the same cycle, and s_ready=0 until the next load_start.
REQ-042 SHALL cover: K=1, CIN=1, NSET=1 with a single beat carrying s_last -> FULL after 1 beat, and DEPTH=1 handled without an address-width error.

Source files
------------

// File: rtl/weight_buf_pkg.sv
// rtl/weight_buf_pkg.sv - shared types and sizing helper for the weight buffer
package weight_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // A one-entry buffer still needs a 1-bit address port; $clog2(1) would give 0.
    function automatic int addr_width(input int depth);
        if (depth <= 1) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/weight_bank.sv
// rtl/weight_bank.sv - DEPTH x DW register bank, synchronous write, flat combinational read
//   clk   : write clock
//   wen   : write enable for entry waddr
//   waddr : write address
//   din   : write data
//   rdata : all entries, entry i at [i*DW +: DW]
module weight_bank #(
    parameter int DW    = 8,
    parameter int DEPTH = 54,
    parameter int AW    = 6
) (
    input  logic                clk,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       din,
    output logic [DEPTH*DW-1:0] rdata
);

    // One register per entry with its own address decode; storage is
    // deliberately not reset, a bank is only meaningful after a full load.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [DW-1:0] entry_q;
        logic [DW-1:0] entry_d;

        always_comb begin
            entry_d = entry_q;
            if (wen && (waddr == AW'(i))) begin
                entry_d = din;
            end
        end

        always_ff @(posedge clk) begin
            entry_q <= entry_d;
        end

        assign rdata[i*DW +: DW] = entry_q;
    end

endmodule

// File: rtl/weight_buf.sv
// rtl/weight_buf.sv - ping-pong weight buffer: stream load into shadow bank, swap to active
//   clk, rst_n          : clock, asynchronous active-low reset
//   load_start          : opens a load into the shadow bank (IDLE only)
//   s_valid/s_ready/s_data/s_last : load byte stream
//   swap                : promotes a complete shadow bank to active (FULL only)
//   dout                : all active-bank weights, entry i at [i*DW +: DW]
//   dout_valid          : active bank holds a complete load
//   loaded              : shadow bank complete, awaiting swap
//   err                 : sticky framing error, cleared by the next accepted load_start
module weight_buf
    import weight_buf_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int K     = 3,
    parameter  int CIN   = 3,
    parameter  int NSET  = 2,
    localparam int DEPTH = K * K * CIN * NSET,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DW-1:0]       s_data,
    input  logic                s_last,
    input  logic                swap,
    output logic [DEPTH*DW-1:0] dout,
    output logic                dout_valid,
    output logic                loaded,
    output logic                err
);

    state_e        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          act_sel_q, act_sel_d;
    logic          dout_valid_q, dout_valid_d;
    logic          loaded_q, loaded_d;
    logic          err_q, err_d;

    logic                beat;
    logic                at_last;
    logic [DEPTH*DW-1:0] rdata0;
    logic [DEPTH*DW-1:0] rdata1;

    assign s_ready = (state_q == ST_LOAD);
    assign beat    = s_valid && s_ready;
    assign at_last = (waddr_q == AW'(DEPTH - 1));

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        act_sel_d    = act_sel_q;
        dout_valid_d = dout_valid_q;
        loaded_d     = loaded_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    waddr_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (at_last) begin
                        // Last slot filled: data is kept even if s_last was missing.
                        state_d  = ST_FULL;
                        loaded_d = 1'b1;
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        waddr_d = waddr_q + AW'(1);
                    end
                end
            end
            ST_FULL: begin
                if (swap) begin
                    act_sel_d    = ~act_sel_q;
                    dout_valid_d = 1'b1;
                    loaded_d     = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            waddr_q      <= '0;
            act_sel_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            act_sel_q    <= act_sel_d;
            dout_valid_q <= dout_valid_d;
            loaded_q     <= loaded_d;
            err_q        <= err_d;
        end
    end

    // Writes only ever target the shadow bank (the one act_sel does not name).
    weight_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
        .clk   (clk),
        .wen   (beat && act_sel_q),
        .waddr (waddr_q),
        .din   (s_data),
        .rdata (rdata0)
    );

    weight_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
        .clk   (clk),
        .wen   (beat && !act_sel_q),
        .waddr (waddr_q),
        .din   (s_data),
        .rdata (rdata1)
    );

    assign dout       = act_sel_q ? rdata1 : rdata0;
    assign dout_valid = dout_valid_q;
    assign loaded     = loaded_q;
    assign err        = err_q;

endmodule

// File: tb/tb_weight_buf.sv
// tb/tb_weight_buf.sv - scoreboard bench for weight_buf (default and single-entry configurations)
module tb_weight_buf;

    localparam int DW = 8;
    localparam int DEPTH = 54;
    localparam int W = DEPTH * DW;

    localparam int K_DLO = 0, K_DHI = 1, K_DVAL = 2, K_ERR = 3, K_LOADED = 4,
                   K_SRDY = 5, K_DOUT = 6, K_LOADED2 = 7, K_ERR2 = 8, K_SRDY2 = 9,
                   K_DOUT2 = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0, s_valid = 1'b0, s_last = 1'b0, swap = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready, dout_valid, loaded, err;
    logic [W-1:0] dout;

    logic load_start2 = 1'b0, s_valid2 = 1'b0, s_last2 = 1'b0, swap2 = 1'b0;
    logic [DW-1:0] s_data2 = '0;
    logic s_ready2, dout_valid2, loaded2, err2;
    logic [DW-1:0] dout2;

    int checks = 0;
    int errors = 0;
    int kq[$];
    logic [W-1:0] vq[$];

    logic [W-1:0] bank_a, bank_b, bank_c, bank_x;

    always #5 clk = ~clk;

    weight_buf #(.DW(DW), .K(3), .CIN(3), .NSET(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .swap(swap), .dout(dout), .dout_valid(dout_valid), .loaded(loaded), .err(err)
    );

    weight_buf #(.DW(DW), .K(1), .CIN(1), .NSET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_last(s_last2),
        .swap(swap2), .dout(dout2), .dout_valid(dout_valid2), .loaded(loaded2), .err(err2)
    );

    function automatic string kname(input int k);
        case (k)
            K_DLO: return "dout_lo";
            K_DHI: return "dout_hi";
            K_DVAL: return "dout_valid";
            K_ERR: return "err";
            K_LOADED: return "loaded";
            K_SRDY: return "s_ready";
            K_DOUT: return "dout_all";
            K_LOADED2: return "d1_loaded";
            K_ERR2: return "d1_err";
            K_SRDY2: return "d1_s_ready";
            default: return "d1_dout";
        endcase
    endfunction

    task automatic expect_val(input int k, input logic [W-1:0] v);
        kq.push_back(k);
        vq.push_back(v);
    endtask

    // Monitor: pops every pending expectation and compares against live outputs.
    always @(negedge clk) begin
        while (kq.size() > 0) begin
            int k;
            logic [W-1:0] v, act;
            k = kq.pop_front();
            v = vq.pop_front();
            act = '0;
            case (k)
                K_DLO: act = W'(dout[7:0]);
                K_DHI: act = W'(dout[431:424]);
                K_DVAL: act = W'(dout_valid);
                K_ERR: act = W'(err);
                K_LOADED: act = W'(loaded);
                K_SRDY: act = W'(s_ready);
                K_DOUT: act = dout;
                K_LOADED2: act = W'(loaded2);
                K_ERR2: act = W'(err2);
                K_SRDY2: act = W'(s_ready2);
                default: act = W'(dout2);
            endcase
            checks++;
            if (act !== v) begin
                errors++;
                if (k == K_DOUT)
                    $display("FAIL %s: got lo=%h hi=%h, want lo=%h hi=%h", kname(k),
                             act[63:0], act[W-1:W-64], v[63:0], v[W-1:W-64]);
                else
                    $display("FAIL %s: got %0h, want %0h", kname(k), act[31:0], v[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats of base+i; s_last on beat last_at (1-based, 0 = never).
    // With toggle, s_valid is randomly dropped; with hold, dout is checked every cycle.
    task automatic load_beats(input int n, input int base, input int last_at,
                              input bit toggle, input bit hold, input logic [W-1:0] hold_val,
                              output logic [W-1:0] model);
        int i, guard;
        logic v;
        model = '0;
        i = 0;
        guard = 0;
        while (i < n && guard < 600) begin
            v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data = DW'(base + i);
            s_last = (i + 1 == last_at);
            step();
            if (v) begin
                model[i*DW +: DW] = DW'(base + i);
                i++;
            end
            if (hold) expect_val(K_DOUT, hold_val);
            guard++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d beats, want %0d", i, n);
        end
    endtask

    initial begin
        bank_x = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        expect_val(K_DVAL, 0);
        expect_val(K_ERR, 0);
        expect_val(K_LOADED, 0);
        expect_val(K_SRDY, 0);

        // Full load 1..54, then swap
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        expect_val(K_SRDY, 1);
        load_beats(54, 1, 54, 1'b0, 1'b0, bank_x, bank_a);
        expect_val(K_LOADED, 1);
        expect_val(K_ERR, 0);
        expect_val(K_SRDY, 0);
        swap = 1'b1;
        step();
        swap = 1'b0;
        expect_val(K_DLO, 1);
        expect_val(K_DHI, 54);
        expect_val(K_DVAL, 1);
        expect_val(K_ERR, 0);
        expect_val(K_LOADED, 0);
        expect_val(K_DOUT, bank_a);

        // Early s_last on beat 10
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_beats(10, 8'h55, 10, 1'b0, 1'b1, bank_a, bank_x);
        expect_val(K_ERR, 1);
        expect_val(K_LOADED, 0);
        expect_val(K_SRDY, 0);
        expect_val(K_DVAL, 1);
        step();
        expect_val(K_SRDY, 0);
        expect_val(K_ERR, 1);
        expect_val(K_DOUT, bank_a);

        // Swap in IDLE is ignored
        swap = 1'b1;
        step();
        swap = 1'b0;
        expect_val(K_DOUT, bank_a);
        expect_val(K_DVAL, 1);

        // Swap in LOAD is ignored; then a toggled-valid load of A0+i behind an active bank
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        expect_val(K_ERR, 0);
        swap = 1'b1;
        step();
        swap = 1'b0;
        expect_val(K_SRDY, 1);
        expect_val(K_DOUT, bank_a);
        load_beats(54, 8'hA0, 54, 1'b1, 1'b1, bank_a, bank_b);
        expect_val(K_LOADED, 1);
        expect_val(K_DOUT, bank_a);
        swap = 1'b1;
        step();
        swap = 1'b0;
        expect_val(K_DLO, 8'hA0);
        expect_val(K_DOUT, bank_b);
        expect_val(K_DVAL, 1);

        // Asynchronous reset at beat 20
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_beats(19, 8'h30, 0, 1'b0, 1'b0, bank_x, bank_x);
        s_valid = 1'b1;
        s_data = 8'h43;
        #2;
        rst_n = 1'b0;
        expect_val(K_DVAL, 0);
        expect_val(K_LOADED, 0);
        expect_val(K_ERR, 0);
        expect_val(K_SRDY, 0);
        step();
        rst_n = 1'b1;
        step();
        expect_val(K_SRDY, 0);
        step();
        expect_val(K_SRDY, 0);
        expect_val(K_DVAL, 0);
        s_valid = 1'b0;

        // Fresh load after reset, then load_start together with swap in FULL
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        expect_val(K_SRDY, 1);
        load_beats(54, 8'h10, 54, 1'b0, 1'b0, bank_x, bank_c);
        load_start = 1'b1;
        swap = 1'b1;
        step();
        load_start = 1'b0;
        swap = 1'b0;
        expect_val(K_DVAL, 1);
        expect_val(K_SRDY, 0);
        expect_val(K_DOUT, bank_c);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        expect_val(K_SRDY, 1);

        // Missing s_last on beat 54: err, data kept in FULL; next load_start clears err
        load_beats(54, 8'hC0, 0, 1'b0, 1'b1, bank_c, bank_b);
        expect_val(K_ERR, 1);
        expect_val(K_SRDY, 0);
        swap = 1'b1;
        step();
        swap = 1'b0;
        expect_val(K_DOUT, bank_b);
        expect_val(K_ERR, 1);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        expect_val(K_ERR, 0);

        // Single-entry configuration
        load_start2 = 1'b1;
        step();
        load_start2 = 1'b0;
        expect_val(K_SRDY2, 1);
        s_valid2 = 1'b1;
        s_data2 = 8'h5A;
        s_last2 = 1'b1;
        step();
        s_valid2 = 1'b0;
        s_last2 = 1'b0;
        expect_val(K_LOADED2, 1);
        expect_val(K_ERR2, 0);
        expect_val(K_SRDY2, 0);
        swap2 = 1'b1;
        step();
        swap2 = 1'b0;
        expect_val(K_DOUT2, W'(8'h5A));
        expect_val(K_LOADED2, 0);

        step();
        step();
        if (kq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", kq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
